// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants for the register-file writeback scheduler: register
// selector codes, writeback requester IDs and a one-hot decode helper.
package regfile_wb_scheduler_pkg;

   localparam int unsigned NUM_REGS = 8;
   localparam int unsigned SEL_W    = 3;
   localparam int unsigned DATA_W   = 8;

   // Register selector codes
   localparam logic [2:0] R0 = 3'd0;
   localparam logic [2:0] R1 = 3'd1;
   localparam logic [2:0] R2 = 3'd2;
   localparam logic [2:0] R3 = 3'd3;
   localparam logic [2:0] R4 = 3'd4;
   localparam logic [2:0] R5 = 3'd5;
   localparam logic [2:0] R6 = 3'd6;
   localparam logic [2:0] R7 = 3'd7;

   // Writeback requester IDs
   localparam logic REQ_ALU = 1'b0;
   localparam logic REQ_LD  = 1'b1;

   // One-hot mask for a register selector (bit i = Ri)
   function automatic logic [7:0] reg_onehot(input logic [2:0] sel);
      reg_onehot = 8'h01 << sel;
   endfunction

endpackage

// File: rtl/regfile_wb_scheduler_wb_rr_arbiter.sv
// Two-requester round-robin arbiter. The requester that did not win the
// last grant wins a tie; the pointer only moves when a grant is issued,
// and a grant always completes a transfer because ready == grant.
module wb_rr_arbiter
   import regfile_wb_scheduler_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   output logic [1:0] grant
);

   logic last_grant;

   // Grant selection: single requester wins outright, tie goes to the one not granted last
   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11: begin
            if (last_grant == REQ_LD) begin
               grant = 2'b01;
            end else begin
               grant = 2'b10;
            end
         end
         default: grant = 2'b00;
      endcase
   end

   // Last-grant pointer; reset value gives the ALU priority
   always_ff @(posedge clk) begin
      if (!reset) begin
         last_grant <= REQ_LD;
      end else if (grant[0]) begin
         last_grant <= REQ_ALU;
      end else if (grant[1]) begin
         last_grant <= REQ_LD;
      end else begin
         last_grant <= last_grant;
      end
   end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler: per-register busy scoreboard gating
// issue, round-robin arbitration of ALU/load writebacks, a one-cycle
// registered write port and a sticky error for writes to idle registers.
module regfile_wb_scheduler
   import regfile_wb_scheduler_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       iss_valid,
   input  logic [2:0] iss_src1,
   input  logic [2:0] iss_src2,
   input  logic [2:0] iss_dest,
   input  logic       iss_wr,
   output logic       iss_stall,
   input  logic       alu_valid,
   output logic       alu_ready,
   input  logic [2:0] alu_dest,
   input  logic [7:0] alu_data,
   input  logic       ld_valid,
   output logic       ld_ready,
   input  logic [2:0] ld_dest,
   input  logic [7:0] ld_data,
   output logic       wb_en,
   output logic [2:0] dest_bus_selector,
   output logic [7:0] wb_data,
   output logic [7:0] busy,
   output logic       wb_err
);

   logic [1:0] req;
   logic [1:0] grant;
   logic [7:0] issue_set;
   logic [7:0] wb_clear;
   logic       wb_en_q;

   // Requests are masked while reset is low so nothing can transfer then
   assign req = {ld_valid & reset, alu_valid & reset};

   wb_rr_arbiter u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .grant (grant)
   );

   assign alu_ready = grant[0];
   assign ld_ready  = grant[1];

   // A pending write port pulse is suppressed while reset is held low
   assign wb_en = wb_en_q & reset;

   // Scoreboard hazard detection and set/clear masks for this edge
   always_comb begin
      iss_stall = iss_valid & (busy[iss_src1] | busy[iss_src2] | (iss_wr & busy[iss_dest]));
      if (iss_valid && !iss_stall && iss_wr) begin
         issue_set = reg_onehot(iss_dest);
      end else begin
         issue_set = 8'h00;
      end
      if (wb_en_q) begin
         wb_clear = reg_onehot(dest_bus_selector);
      end else begin
         wb_clear = 8'h00;
      end
   end

   // Busy scoreboard: clear on writeback, set on issue; set wins on collision
   always_ff @(posedge clk) begin
      if (!reset) begin
         busy <= 8'h00;
      end else begin
         busy <= (busy & ~wb_clear) | issue_set;
      end
   end

   // Write-port register: captures the granted request, one-cycle latency
   always_ff @(posedge clk) begin
      if (!reset) begin
         wb_en_q           <= 1'b0;
         dest_bus_selector <= 3'b000;
         wb_data           <= 8'h00;
      end else if (grant[0]) begin
         wb_en_q           <= 1'b1;
         dest_bus_selector <= alu_dest;
         wb_data           <= alu_data;
      end else if (grant[1]) begin
         wb_en_q           <= 1'b1;
         dest_bus_selector <= ld_dest;
         wb_data           <= ld_data;
      end else begin
         wb_en_q           <= 1'b0;
         dest_bus_selector <= dest_bus_selector;
         wb_data           <= wb_data;
      end
   end

   // Sticky error: a write landed on a register that had no pending result
   always_ff @(posedge clk) begin
      if (!reset) begin
         wb_err <= 1'b0;
      end else if (wb_en_q && !busy[dest_bus_selector]) begin
         wb_err <= 1'b1;
      end else begin
         wb_err <= wb_err;
      end
   end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic checked
// against a behavioural model of the scoreboard, arbiter and write port.
module tb_regfile_wb_scheduler;
   import regfile_wb_scheduler_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       iss_valid, iss_wr;
   logic [2:0] iss_src1, iss_src2, iss_dest;
   logic       iss_stall;
   logic       alu_valid, alu_ready, ld_valid, ld_ready;
   logic [2:0] alu_dest, ld_dest;
   logic [7:0] alu_data, ld_data;
   logic       wb_en, wb_err;
   logic [2:0] dest_bus_selector;
   logic [7:0] wb_data, busy;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit [7:0] m_busy;
   bit       m_ld_last;
   bit       m_err;
   bit       m_en;
   bit [2:0] m_sel;
   bit [7:0] m_data;
   bit       e_galu, e_gld;
   logic     obs_alu_ready, obs_wb_en;

   always #5 clk = ~clk;

   regfile_wb_scheduler dut (
      .clk               (clk),
      .reset             (reset),
      .iss_valid         (iss_valid),
      .iss_src1          (iss_src1),
      .iss_src2          (iss_src2),
      .iss_dest          (iss_dest),
      .iss_wr            (iss_wr),
      .iss_stall         (iss_stall),
      .alu_valid         (alu_valid),
      .alu_ready         (alu_ready),
      .alu_dest          (alu_dest),
      .alu_data          (alu_data),
      .ld_valid          (ld_valid),
      .ld_ready          (ld_ready),
      .ld_dest           (ld_dest),
      .ld_data           (ld_data),
      .wb_en             (wb_en),
      .dest_bus_selector (dest_bus_selector),
      .wb_data           (wb_data),
      .busy              (busy),
      .wb_err            (wb_err)
   );

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock cycle: compare at the falling edge, advance the model at the rising edge
   task automatic run_cycle();
      bit stall_e;
      @(negedge clk);
      e_galu = 1'b0;
      e_gld  = 1'b0;
      if (reset) begin
         if (alu_valid && ld_valid) begin
            if (m_ld_last) e_galu = 1'b1;
            else           e_gld  = 1'b1;
         end else begin
            e_galu = alu_valid;
            e_gld  = ld_valid;
         end
      end
      stall_e = iss_valid && (m_busy[iss_src1] || m_busy[iss_src2] || (iss_wr && m_busy[iss_dest]));
      obs_alu_ready = alu_ready;
      obs_wb_en     = wb_en;
      check_value("iss_stall", iss_stall, stall_e);
      check_value("alu_ready", alu_ready, e_galu);
      check_value("ld_ready",  ld_ready,  e_gld);
      check_value("wb_en",     wb_en,     m_en && reset);
      check_value("wb_sel",    dest_bus_selector, m_sel);
      check_value("wb_data",   wb_data,   m_data);
      check_value("busy",      busy,      m_busy);
      check_value("wb_err",    wb_err,    m_err);
      @(posedge clk);
      if (!reset) begin
         m_busy = 8'h00; m_ld_last = 1'b1; m_err = 1'b0;
         m_en = 1'b0; m_sel = 3'd0; m_data = 8'h00;
      end else begin
         if (m_en && !m_busy[m_sel]) m_err = 1'b1;
         if (m_en) m_busy[m_sel] = 1'b0;
         if (iss_valid && !stall_e && iss_wr) m_busy[iss_dest] = 1'b1;
         if (e_galu) begin
            m_en = 1'b1; m_sel = alu_dest; m_data = alu_data; m_ld_last = 1'b0;
         end else if (e_gld) begin
            m_en = 1'b1; m_sel = ld_dest; m_data = ld_data; m_ld_last = 1'b1;
         end else begin
            m_en = 1'b0;
         end
      end
      #1;
   endtask

   initial begin
      reset = 1'b0; iss_valid = 1'b0; iss_wr = 1'b0;
      iss_src1 = R0; iss_src2 = R0; iss_dest = R0;
      alu_valid = 1'b0; alu_dest = R0; alu_data = 8'h00;
      ld_valid = 1'b0; ld_dest = R0; ld_data = 8'h00;
      m_busy = 8'h00; m_ld_last = 1'b1; m_err = 1'b0;
      m_en = 1'b0; m_sel = 3'd0; m_data = 8'h00;
      @(posedge clk); #1;

      // Reset state
      run_cycle(); run_cycle();
      check_value("rst_busy", busy, 8'h00);
      check_value("rst_wb_en", wb_en, 1'b0);
      check_value("rst_sel", dest_bus_selector, R0);
      check_value("rst_data", wb_data, 8'h00);
      check_value("rst_err", wb_err, 1'b0);
      reset = 1'b1;

      // Issue R3 <- R1,R2 then a dependent issue stalls until R3 is written back
      iss_valid = 1'b1; iss_src1 = R1; iss_src2 = R2; iss_dest = R3; iss_wr = 1'b1;
      run_cycle();
      check_value("iss_busy3", busy, 8'h08);
      iss_src1 = R3; iss_dest = R4;
      run_cycle();
      alu_valid = 1'b1; alu_dest = R3; alu_data = 8'hA5;
      run_cycle();
      alu_valid = 1'b0;
      check_value("wb_a5_en", wb_en, 1'b1);
      check_value("wb_a5_sel", dest_bus_selector, R3);
      check_value("wb_a5_data", wb_data, 8'hA5);
      check_value("dep_stall", iss_stall, 1'b1);
      run_cycle();
      check_value("busy3_clr", busy, 8'h00);
      check_value("err_clean", wb_err, 1'b0);
      run_cycle();
      check_value("dep_issued", busy, 8'h10);
      iss_valid = 1'b0;

      // Writeback to idle R6 raises the sticky error
      alu_valid = 1'b1; alu_dest = R6; alu_data = 8'h3C;
      run_cycle();
      alu_valid = 1'b0;
      run_cycle();
      check_value("err_set", wb_err, 1'b1);
      run_cycle(); run_cycle();
      check_value("err_sticky", wb_err, 1'b1);

      // Clear and issue-set of R2 on the same edge: set wins
      alu_valid = 1'b1; alu_dest = R2; alu_data = 8'h77;
      run_cycle();
      alu_valid = 1'b0;
      iss_valid = 1'b1; iss_src1 = R0; iss_src2 = R0; iss_dest = R2; iss_wr = 1'b1;
      run_cycle();
      iss_valid = 1'b0;
      check_value("set_wins", busy, 8'h14);

      // Both requesters valid for four cycles: ALU, LD, ALU, LD back to back
      reset = 1'b0;
      run_cycle();
      reset = 1'b1;
      alu_valid = 1'b1; alu_dest = R3; alu_data = 8'h01;
      ld_valid  = 1'b1; ld_dest  = R5; ld_data  = 8'h02;
      for (int k = 0; k < 4; k++) begin
         run_cycle();
         check_value("rr_order", obs_alu_ready, (k % 2 == 0) ? 1'b1 : 1'b0);
         check_value("rr_wb_en", wb_en, 1'b1);
         if (obs_alu_ready) alu_data = alu_data + 8'h10;
         else               ld_data  = ld_data + 8'h10;
      end
      alu_valid = 1'b0; ld_valid = 1'b0;
      run_cycle();

      // Reset the cycle after a transfer: no write pulse, scoreboard cleared, ALU first
      alu_valid = 1'b1; alu_dest = R1; alu_data = 8'h5A;
      run_cycle();
      alu_valid = 1'b0; reset = 1'b0;
      run_cycle();
      check_value("rst_no_pulse", obs_wb_en, 1'b0);
      reset = 1'b1;
      check_value("rst_busy2", busy, 8'h00);
      check_value("rst_wb_en2", wb_en, 1'b0);
      alu_valid = 1'b1; ld_valid = 1'b1;
      run_cycle();
      check_value("rst_prio_alu", obs_alu_ready, 1'b1);
      alu_valid = 1'b0; ld_valid = 1'b0;
      run_cycle();

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         reset     = ($urandom_range(0, 49) != 0);
         iss_valid = $urandom_range(0, 1);
         iss_wr    = $urandom_range(0, 1);
         iss_src1  = 3'($urandom_range(0, 7));
         iss_src2  = 3'($urandom_range(0, 7));
         iss_dest  = 3'($urandom_range(0, 7));
         if (!(alu_valid && !e_galu)) begin
            alu_valid = $urandom_range(0, 1);
            alu_dest  = 3'($urandom_range(0, 7));
            alu_data  = 8'($urandom);
         end
         if (!(ld_valid && !e_gld)) begin
            ld_valid = $urandom_range(0, 1);
            ld_dest  = 3'($urandom_range(0, 7));
            ld_data  = 8'($urandom);
         end
         run_cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
